// File: rtl/count_run_controller.sv
// Run/pause/clear sequencer for the 4-bit display counter: a prescaler on mainClock
// yields the advance tick, and a small FSM decides direction, wrap or stop-at-limit.
//
// state | meaning
// IDLE  | stopped after reset or clear, waiting for start
// RUN   | prescaler running, count advances on each internal tick
// PAUSE | count frozen by stop, start resumes with a fresh prescaler
// DONE  | one-shot reached its terminal value, start reloads and runs
module count_run_controller #(
    parameter int DIV_WIDTH = 24,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 mainClock,
    input  logic                 reset,
    input  logic                 startBtn,
    input  logic                 stopBtn,
    input  logic                 clearBtn,
    input  logic                 upDown,
    input  logic                 oneShot,
    input  logic [CNT_WIDTH-1:0] limit,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 tick,
    output logic                 running,
    output logic                 done
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t               state, state_nxt;
    logic [DIV_WIDTH-1:0] prescaler, prescaler_nxt;
    logic [CNT_WIDTH-1:0] count_nxt, start_val;
    logic                 start_prev, stop_prev, clear_prev;
    logic                 start_press, stop_press, clear_press;
    logic                 tick_int;

    assign start_press = startBtn & ~start_prev;
    assign stop_press  = stopBtn  & ~stop_prev;
    assign clear_press = clearBtn & ~clear_prev;

    assign start_val = upDown ? '0 : limit;
    // A stop or clear in the same cycle wins over the advance.
    assign tick_int  = (state == RUN) && (&prescaler) && !stop_press && !clear_press;

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        if (clear_press) begin
            state_nxt = IDLE;
            count_nxt = start_val;
        end else begin
            case (state)
                IDLE: begin
                    if (start_press) state_nxt = RUN;
                end
                RUN: begin
                    if (stop_press) begin
                        state_nxt = PAUSE;
                    end else if (tick_int) begin
                        if (upDown) begin
                            if (count == limit) begin
                                if (oneShot) state_nxt = DONE;
                                else         count_nxt = '0;
                            end else begin
                                count_nxt = count + 1'b1;
                            end
                        end else begin
                            if (count == '0) begin
                                if (oneShot) state_nxt = DONE;
                                else         count_nxt = limit;
                            end else begin
                                count_nxt = count - 1'b1;
                            end
                        end
                    end
                end
                PAUSE: begin
                    if (start_press) state_nxt = RUN;
                end
                DONE: begin
                    if (start_press) begin
                        state_nxt = RUN;
                        count_nxt = start_val;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
        prescaler_nxt = (state == RUN && state_nxt == RUN) ? prescaler + 1'b1 : '0;
    end

    always_ff @(posedge mainClock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Button history resets high so a button held through reset release is not a press.
    always_ff @(posedge mainClock or negedge reset) begin
        if (!reset) begin
            count      <= '0;
            prescaler  <= '0;
            tick       <= 1'b0;
            running    <= 1'b0;
            done       <= 1'b0;
            start_prev <= 1'b1;
            stop_prev  <= 1'b1;
            clear_prev <= 1'b1;
        end else begin
            count      <= count_nxt;
            prescaler  <= prescaler_nxt;
            tick       <= tick_int;
            running    <= (state_nxt == RUN);
            done       <= (state_nxt == DONE) && (state != DONE);
            start_prev <= startBtn;
            stop_prev  <= stopBtn;
            clear_prev <= clearBtn;
        end
    end

endmodule
